// File: rtl/inv_mix_columns_ctrl_pkg.sv
// Shared definitions for the inverse MixColumns sequencer: FSM encoding,
// state geometry and datapath accumulate masks.
// Optional feature macro: INV_MIX_COLUMNS_BYPASS_EN (see inv_mix_columns_ctrl).
package inv_mix_columns_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fsm_state_t;

    localparam int STATE_BYTES = 16;
    localparam int COL_BYTES   = 4;
    localparam int STATE_BITS  = STATE_BYTES * 8;
    localparam int CNT_W       = $clog2(STATE_BYTES);
    localparam int COL_SEL_W   = $clog2(COL_BYTES);

    localparam logic [7:0] DP_MASK_ACC = 8'hFF;
    localparam logic [7:0] DP_MASK_CLR = 8'h00;

endpackage

// File: rtl/inv_mix_columns_ctrl_capture.sv
// Capture side of the inverse MixColumns sequencer: a DP_LAT-deep delay line
// of the issue strobe marks the cycle each datapath result byte is valid;
// those bytes are shifted into a 128-bit assembly register in order 0..15.
module inv_mix_columns_capture
    import inv_mix_columns_ctrl_pkg::*;
#(
    parameter int DP_LAT = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  issue,
    input  logic [7:0]            dp_out_byte,
    output logic                  capture_last,
    output logic [STATE_BITS-1:0] assembled
);

    logic [DP_LAT-1:0] dly_reg;
    logic [DP_LAT-1:0] dly_next;
    logic [CNT_W-1:0]  cap_cnt_reg;
    logic              capture;

    // Delay line: stage 0 takes the issue strobe, every later stage the one before.
    for (genvar gi = 0; gi < DP_LAT; gi++) begin : g_dly
        if (gi == 0) begin : g_head
            assign dly_next[gi] = issue;
        end else begin : g_tail
            assign dly_next[gi] = dly_reg[gi-1];
        end
    end

    assign capture      = dly_reg[DP_LAT-1];
    assign capture_last = capture && (cap_cnt_reg == CNT_W'(STATE_BYTES - 1));

    // Advance the delay line; on a capture cycle shift the result byte in and count it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dly_reg     <= '0;
            cap_cnt_reg <= '0;
            assembled   <= '0;
        end else begin
            dly_reg <= dly_next;
            if (capture) begin
                cap_cnt_reg <= cap_cnt_reg + 1'b1;
                assembled   <= {assembled[STATE_BITS-9:0], dp_out_byte};
            end
        end
    end

endmodule

// File: rtl/inv_mix_columns_ctrl.sv
// Byte-serial inverse MixColumns sequencer. Accepts a 128-bit state, feeds it
// column-major to an external datapath with a per-byte accumulate mask, and
// reassembles the returned bytes into the result.
// Optional feature macro: INV_MIX_COLUMNS_BYPASS_EN adds a 'bypass' input that
// passes the state through unchanged with identical timing (final round).
module inv_mix_columns_ctrl
    import inv_mix_columns_ctrl_pkg::*;
#(
    parameter int DP_LAT = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [STATE_BITS-1:0] in_state,
`ifdef INV_MIX_COLUMNS_BYPASS_EN
    input  logic                  bypass,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [STATE_BITS-1:0] out_state,
    output logic                  busy,
    output logic [7:0]            dp_in_byte,
    output logic                  dp_ready,
    output logic [7:0]            dp_enable,
    input  logic [7:0]            dp_out_byte
);

    fsm_state_t            state_reg;
    fsm_state_t            state_next;
    logic [CNT_W-1:0]      issue_cnt_reg;
    logic [STATE_BITS-1:0] shift_reg;
    logic                  capture_last;
    logic [STATE_BITS-1:0] assembled;
    logic                  issuing;

`ifdef INV_MIX_COLUMNS_BYPASS_EN
    logic                  bypass_reg;
`endif

    assign issuing = (state_reg == ISSUE);

    // State register plus input shift register. The shift register rotates so
    // that after 16 issues it again holds the original state (used by bypass).
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            issue_cnt_reg <= '0;
            shift_reg     <= '0;
`ifdef INV_MIX_COLUMNS_BYPASS_EN
            bypass_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && in_valid) begin
                shift_reg     <= in_state;
                issue_cnt_reg <= '0;
`ifdef INV_MIX_COLUMNS_BYPASS_EN
                bypass_reg    <= bypass;
`endif
            end else if (issuing) begin
                shift_reg     <= {shift_reg[STATE_BITS-9:0], shift_reg[STATE_BITS-1 -: 8]};
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b1;
        out_valid  = 1'b0;
        dp_in_byte = 8'h00;
        dp_ready   = 1'b0;
        dp_enable  = DP_MASK_CLR;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = ISSUE;
            end
            ISSUE: begin
                dp_in_byte = shift_reg[STATE_BITS-1 -: 8];
`ifdef INV_MIX_COLUMNS_BYPASS_EN
                dp_ready   = !bypass_reg;
`else
                dp_ready   = 1'b1;
`endif
                // First byte of each column restarts the accumulation chain.
                dp_enable  = (issue_cnt_reg[COL_SEL_W-1:0] == '0) ? DP_MASK_CLR : DP_MASK_ACC;
                if (issue_cnt_reg == CNT_W'(STATE_BYTES - 1)) state_next = DRAIN;
            end
            DRAIN: begin
                if (capture_last) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture timing follows the issue window so bypass keeps identical latency.
    inv_mix_columns_capture #(
        .DP_LAT(DP_LAT)
    ) u_capture (
        .clock       (clock),
        .reset_n     (reset_n),
        .issue       (issuing),
        .dp_out_byte (dp_out_byte),
        .capture_last(capture_last),
        .assembled   (assembled)
    );

`ifdef INV_MIX_COLUMNS_BYPASS_EN
    assign out_state = bypass_reg ? shift_reg : assembled;
`else
    assign out_state = assembled;
`endif

endmodule

// File: doc/inv_mix_columns_ctrl.md
Name: inv_mix_columns_ctrl

Overview:
- Sequencer for the byte-serial inverse MixColumns datapath in the decryption round.
- Accepts a 128-bit state over a valid/ready handshake and issues it to the datapath one byte per cycle, column-major, with the correct per-byte accumulate mask.
- Captures the datapath's output bytes and reassembles them into a 128-bit result, presented over a valid/ready handshake.
- Sits between the inverse ShiftRows/SubBytes/AddRoundKey stage and the next round register.

Parameters:
- DP_LAT, 4, cycles from issuing byte i to the datapath until output byte i is valid on dp_out_byte; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  in_state valid
- in_ready  out  1  controller can accept a state
- in_state  in  128  input state; byte 0 = [127:120], column c = bytes 4c..4c+3
- out_valid  out  1  out_state valid
- out_ready  in  1  downstream accepts out_state
- out_state  out  128  InvMixColumns(in_state), same byte order
- busy  out  1  high in every state except IDLE
- dp_in_byte  out  8  byte to datapath
- dp_ready  out  1  byte valid to datapath
- dp_enable  out  8  accumulate mask to datapath
- dp_out_byte  in  8  datapath result byte

Behaviour:
- Reset and clock: one clock. reset_n is synchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_state=0, busy=0, dp_in_byte=0, dp_ready=0, dp_enable=8'h00. All counters are 0.
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: latch in_state into a 128-bit shift register, clear the issue counter, go to ISSUE.
- ISSUE (16 cycles, issue counter k = 0..15, 4 bits):
  - dp_in_byte = byte k; dp_ready=1.
  - dp_enable=8'h00 when k[1:0]==0 (clears the accumulation chain at each column start); otherwise 8'hFF.
  - After k=15, go to DRAIN.
- DRAIN:
  - dp_ready=0, dp_enable=8'h00, dp_in_byte=0.
  - Wait until all 16 output bytes are captured, then go to HOLD.
- Capture rule:
  - A 4-bit capture counter j increments each cycle a capture occurs.
  - Output byte j is sampled from dp_out_byte exactly DP_LAT cycles after byte j was issued, tracked with a DP_LAT-deep delay line of dp_ready.
  - Bytes are shifted into the out_state assembly register in order 0..15.
  - Captures overlap ISSUE when DP_LAT<16.
- HOLD:
  - out_valid=1.
  - out_state and out_valid stay stable until out_ready.
  - On out_valid&&out_ready, go to IDLE and drop out_valid the next cycle.
- Latency and throughput:
  - Accept at cycle 0, first issue at cycle 1, last capture at cycle 16+DP_LAT, out_valid at cycle 17+DP_LAT (21 with default DP_LAT).
  - Throughput: one state per 18+DP_LAT cycles with out_ready held high. No overlap of consecutive states.
- Boundaries:
  - in_valid while busy: in_ready=0, request ignored, in_state not sampled.
  - out_ready asserted before out_valid: no effect.
  - out_ready held low: HOLD indefinitely, in_ready stays 0.
  - Reset asserted mid-ISSUE/DRAIN/HOLD: return to IDLE next cycle with reset values. The partial result is discarded and the datapath is left unsynchronised until the next column start. The enable=0 on each column's first byte guarantees stale datapath contents never reach a captured byte.
  - Simultaneous out_ready handshake and in_valid in HOLD: the new state is not accepted in that cycle. It is accepted in IDLE the following cycle.

Optional Feature:
- Macro: INV_MIX_COLUMNS_BYPASS_EN.
- With the macro defined:
  - An extra input port bypass (1 bit) is added, sampled with in_state at the accept handshake.
  - When the latched bypass=1, dp_ready stays 0 throughout and out_state = in_state unchanged.
  - Latency and handshake timing are identical to the normal path (17+DP_LAT cycles), for the final decryption round.
- Without the macro: no bypass port, and every state goes through the datapath.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2, HOLD=2'd3.
  - Constants STATE_BYTES=16, COL_BYTES=4, DP_MASK_ACC=8'hFF, DP_MASK_CLR=8'h00.
- One sub-module: inv_mix_columns_capture, containing the DP_LAT delay line, capture counter and 128-bit assembly shift register.

Test Plan:
- FIPS-197 vectors: in_state = 8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> out_state = db135345_f20a225c_01010101_d4d4d4d5, out_valid first high at cycle 21 after accept.
- Enable pattern: during ISSUE, dp_enable must read 00,FF,FF,FF repeated four times. dp_ready must be high for exactly 16 consecutive cycles.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_state stable, in_ready=0, second in_valid ignored. Release -> out_valid drops next cycle, in_ready=1.
- Reset mid-operation: pull reset_n low at issue k=7 for one cycle -> IDLE, all outputs at reset values. A following vector c6c6c6c6 ×4 -> c6c6c6c6 ×4 (stale data is not leaked).
- Back-to-back: two states with out_ready=1 -> second accepted exactly 22 cycles after the first, both results correct.
- Bypass (macro defined, bypass=1): in_state=00112233_44556677_8899aabb_ccddeeff -> identical out_state at cycle 21, dp_ready never asserted.
